// File: rtl/arith_sequencer.sv
// Issue/writeback sequencer for the 8-bit arithmetic path: accepts one instruction
// byte, fetches operand B, drives the arithmetic unit and writes acc/flags back.
module arith_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    input  logic       acc_load,
    input  logic [7:0] acc_load_data,
    output logic [2:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic [2:0] au_opcode,
    output logic [7:0] au_operand_a,
    output logic [7:0] au_operand_b,
    input  logic [7:0] au_result,
    output logic [7:0] acc,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       done,
    output logic       err_illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2,
        EXEC = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [2:0] OP_ADD     = 3'b100;
    localparam logic [2:0] OP_SUB     = 3'b101;

    state_t     state, state_next;
    logic [2:0] op_q;
    logic [7:0] opa_q, opb_q;
    logic       accept;
    logic       instr_legal;
    logic [8:0] sum9;
    logic       carry_next;

    always_comb begin
        instr_legal = (instr[7:6] == MODE_ARITH) &&
                      ((instr[2:0] == OP_ADD) || (instr[2:0] == OP_SUB));
        sum9        = {1'b0, opa_q} + {1'b0, opb_q};
        // only ADD and SUB can ever be latched, so anything else is SUB
        carry_next  = (op_q == OP_ADD) ? sum9[8] : (opa_q < opb_q);
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        au_opcode   = '0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid;
                if (instr_valid && instr_legal) begin
                    state_next = READ;
                end
            end
            READ: state_next = LOAD;
            LOAD: state_next = EXEC;
            EXEC: begin
                au_opcode  = op_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign au_operand_a = opa_q;
    assign au_operand_b = opb_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            reg_rd_addr <= '0;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc         <= '0;
            flag_zero   <= 1'b0;
            flag_carry  <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state       <= state_next;
            done        <= (state == EXEC);
            err_illegal <= accept && !instr_legal;
            if (accept && instr_legal) begin
                reg_rd_addr <= instr[5:3];
                op_q        <= instr[2:0];
            end
            // a same-edge preload lands in acc before LOAD snapshots it
            if (state == LOAD) begin
                opa_q <= acc;
                opb_q <= reg_rd_data;
            end
            if (state == EXEC) begin
                acc        <= au_result;
                flag_zero  <= (au_result == 8'h00);
                flag_carry <= carry_next;
            end else if (state == IDLE && acc_load) begin
                acc <= acc_load_data;
            end
        end
    end

endmodule

// File: doc/arith_sequencer.md
# arith_sequencer

Issue and writeback controller for the 8-bit CPU's arithmetic path. It sits directly upstream of the arithmetic unit. It accepts one instruction byte at a time and fetches operand B from the register file. It then presents opcode and operands to the arithmetic unit, and writes the returned result into the accumulator together with zero and carry flags.

## Interface
Parameters:
- none. The data width is fixed at 8 bits and the register index at 3 bits.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: instruction byte on `instr` is offered.
- `instr` in 8: instruction byte, laid out as [7:6] mode, [5:3] source register, [2:0] op.
- `instr_ready` out 1: the block accepts `instr` this cycle.
- `acc_load` in 1: load the accumulator from `acc_load_data`.
- `acc_load_data` in 8: accumulator preload value.
- `reg_rd_addr` out 3: register file read address.
- `reg_rd_data` in 8: register file read data; synchronous read, valid the cycle after the address is presented.
- `au_opcode` out 3: opcode to the arithmetic unit.
- `au_operand_a` out 8: operand A (accumulator snapshot) to the arithmetic unit.
- `au_operand_b` out 8: operand B (register value) to the arithmetic unit.
- `au_result` in 8: combinational result from the arithmetic unit.
- `acc` out 8: accumulator.
- `flag_zero` out 1: last arithmetic result was 0.
- `flag_carry` out 1: carry out of the last ADD, or borrow of the last SUB.
- `done` out 1: one-cycle pulse, accumulator and flags just updated.
- `err_illegal` out 1: one-cycle pulse, an illegal instruction was accepted and dropped.

## Operation
- States are IDLE, READ, LOAD and EXEC. `instr_ready` is 1 only in IDLE.
- A handshake completes on a rising edge when `instr_valid && instr_ready`.
- **Legal instruction:** mode = 2'b01 and op ∈ {3'b100 ADD, 3'b101 SUB}. Bits [5:3] are latched as the register index and [2:0] as the op. The state goes to READ.
- **Illegal instruction:** any other byte. It is consumed, the state stays IDLE, and `err_illegal` pulses in the next cycle. No other state changes.
- **READ:** `reg_rd_addr` is the latched index; go to LOAD.
- **LOAD:** at the end of the cycle, capture `reg_rd_data` into the operand B register and `acc` into the operand A register; go to EXEC.
- **EXEC:** `au_opcode` is the latched op. `au_operand_a` and `au_operand_b` come from the operand registers. At the end of EXEC, the block performs all of the following, then goes to IDLE:
  - `acc` ← `au_result`.
  - `flag_zero` ← (`au_result` == 0).
  - For ADD, `flag_carry` ← bit 8 of the 9-bit A+B, computed locally from the operand registers.
  - For SUB, `flag_carry` ← (A < B), unsigned.
  - `done` pulses in the next cycle.
- Outside EXEC, `au_opcode` = 3'b000, so the arithmetic unit outputs 0. The operand registers hold their last values.
- **acc_load:** honoured only in IDLE, and takes effect on that edge. It is ignored in any other state. Flags are unchanged.
- **acc_load and handshake on the same IDLE edge:** both take effect. The loaded value is the one captured in LOAD.
- Arithmetic is modulo 256, so wrap-around is silent apart from `flag_carry`.

## Timing
- **Reset (async assert, sync deassert):**
  - state = IDLE.
  - `acc`, operand registers, `reg_rd_addr` and `au_opcode` = 0.
  - `flag_zero`, `flag_carry`, `done`, `err_illegal` = 0.
  - `instr_ready` = 1 once `reset_n` is high.
- Reset mid-operation discards the in-flight instruction with no partial writeback.
- **Latency:**
  - Accept edge k.
  - READ during cycle k..k+1.
  - LOAD captures data at edge k+2.
  - EXEC ends at edge k+3, where `acc` and the flags update.
  - `done` is high during cycle k+3..k+4, and `instr_ready` returns in that same cycle.
- **Throughput:** one instruction per 4 cycles. A new instruction may be accepted in the same cycle that `done` is high.
- `err_illegal` is high for exactly one cycle after the accept edge. Back-to-back illegal bytes give back-to-back pulses.
- `instr_valid` held without `instr_ready` has no effect. The instruction is not latched until the handshake.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-EXEC -> all outputs 0 immediately, `instr_ready` = 1 after release, no `done`.
- **ADD:** preload `acc` = 8'h05, R3 = 8'h07, instr 8'b01_011_100 -> `reg_rd_addr` = 3 in READ, `au_opcode` = 100 in EXEC, `acc` = 8'h0C three edges after accept, zero = 0, carry = 0, one `done` pulse.
- **ADD with wrap:** `acc` = 8'hF0, R1 = 8'h10 -> `acc` = 8'h00, zero = 1, carry = 1.
- **SUB with borrow:** `acc` = 8'h03, R2 = 8'h05, instr 8'b01_010_101 -> `acc` = 8'hFE, zero = 0, carry = 1. Then `acc` = 8'h05 minus R2 -> 8'h00, zero = 1, carry = 0.
- **Illegal:** instr 8'b10_000_100, then 8'b01_000_011 -> two consecutive `err_illegal` pulses, `acc` and flags unchanged, no `done`.
- **Back-to-back with simultaneous load:** two legal ADDs with `instr_valid` held high -> accepts 4 cycles apart, second result uses the first result as A. Separately, `acc_load` = 8'h20 on the same edge as accepting ADD R0 (R0 = 8'h01) -> `acc` = 8'h21. `acc_load` during READ/LOAD/EXEC is ignored.
